tile_sequencer: RTL and testbench

Turn-passing controller for the `tile` array of the brute-force solver. It hands a single `myturn` token to one tile at a time in linear (row-major) order. It advances on `passfwd`, backtracks on `passbak`, and re-initialises a tile whenever control retreats past it. It sits between the solver top level (start, abort, status) and the `NUM_TILES` tile instances.

---
 rtl/tile_sequencer_if.sv | 29 ++
 rtl/tile_sequencer.sv | 97 +++++++++
 tb/tb_tile_sequencer.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/tile_sequencer_if.sv
// Handshake bundle between the solver top level, the tile array and tile_sequencer.
// The slave modport is the sequencer's view; master is the driving side.
interface tile_sequencer_if #(
    parameter int NUM_TILES = 81,
    parameter int STEP_W    = 16,
    parameter int IDX_W     = $clog2(NUM_TILES)
);
    logic                 start;
    logic                 abort;
    logic [NUM_TILES-1:0] passfwd;
    logic [NUM_TILES-1:0] passbak;
    logic [NUM_TILES-1:0] myturn;
    logic [NUM_TILES-1:0] tile_clear;
    logic [IDX_W-1:0]     cursor;
    logic                 busy;
    logic                 done;
    logic                 failed;
    logic [STEP_W-1:0]    steps;

    modport slave (
        input  start, abort, passfwd, passbak,
        output myturn, tile_clear, cursor, busy, done, failed, steps
    );

    modport master (
        output start, abort, passfwd, passbak,
        input  myturn, tile_clear, cursor, busy, done, failed, steps
    );
endinterface

// File: rtl/tile_sequencer.sv
// Passes a single turn token along the tile array in row-major order, backtracking
// on exhaustion and re-initialising each tile that control retreats past.
module tile_sequencer #(
    parameter int NUM_TILES = 81,
    parameter int STEP_W    = 16,
    parameter int IDX_W     = $clog2(NUM_TILES)
) (
    input  logic              clock,
    input  logic              reset,
    tile_sequencer_if.slave   bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_GRANT,
        S_WAIT,
        S_RETREAT,
        S_DONE,
        S_FAILED
    } state_t;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  cursor_q, cursor_d;
    logic [STEP_W-1:0] steps_q, steps_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cursor_q <= '0;
            steps_q  <= '0;
        end else begin
            state_q  <= state_d;
            cursor_q <= cursor_d;
            steps_q  <= steps_d;
        end
    end

    // Abort overrides everything; done/failed clear implicitly by leaving their states.
    always_comb begin
        state_d  = state_q;
        cursor_d = cursor_q;
        steps_d  = steps_q;
        if (bus.abort && state_q != S_IDLE) begin
            state_d  = S_IDLE;
            cursor_d = '0;
            steps_d  = '0;
        end else begin
            unique case (state_q)
                S_IDLE, S_DONE, S_FAILED: begin
                    if (bus.start) state_d = S_CLEAR;
                end
                S_CLEAR: begin
                    cursor_d = '0;
                    steps_d  = '0;
                    state_d  = S_GRANT;
                end
                S_GRANT: begin
                    if (steps_q != '1) steps_d = steps_q + STEP_W'(1);
                    state_d = S_WAIT;
                end
                S_WAIT: begin
                    if (bus.passbak[cursor_q]) begin
                        state_d = (cursor_q == '0) ? S_FAILED : S_RETREAT;
                    end else if (bus.passfwd[cursor_q]) begin
                        if (cursor_q == IDX_W'(NUM_TILES - 1)) begin
                            state_d = S_DONE;
                        end else begin
                            cursor_d = cursor_q + IDX_W'(1);
                            state_d  = S_GRANT;
                        end
                    end
                end
                S_RETREAT: begin
                    cursor_d = cursor_q - IDX_W'(1);
                    state_d  = S_GRANT;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Outputs decode registered state only, so no input reaches an output combinationally.
    always_comb begin
        bus.myturn     = '0;
        bus.tile_clear = '0;
        if (state_q == S_GRANT)   bus.myturn[cursor_q]     = 1'b1;
        if (state_q == S_RETREAT) bus.tile_clear[cursor_q] = 1'b1;
        if (state_q == S_CLEAR)   bus.tile_clear           = '1;
    end

    assign bus.cursor = cursor_q;
    assign bus.steps  = steps_q;
    assign bus.busy   = (state_q == S_CLEAR) || (state_q == S_GRANT) ||
                        (state_q == S_WAIT)  || (state_q == S_RETREAT);
    assign bus.done   = (state_q == S_DONE);
    assign bus.failed = (state_q == S_FAILED);
endmodule

// File: tb/tb_tile_sequencer.sv
// Directed bench for tile_sequencer with 4 tiles: expected grants are queued as
// stimulus is planned and popped as the DUT issues each myturn pulse.
module tb_tile_sequencer;
    localparam int NT = 4;
    localparam int SW = 4;

    logic clock;
    logic reset;
    int   n_cmp;
    int   n_err;
    logic [NT-1:0] exp_q[$];

    tile_sequencer_if #(.NUM_TILES(NT), .STEP_W(SW)) bus ();

    tile_sequencer #(.NUM_TILES(NT), .STEP_W(SW)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Wait (bounded) for a grant, then compare it against the head of the scoreboard.
    task automatic wait_grant(output int idx);
        int n;
        logic [NT-1:0] e;
        n = 0;
        while (bus.myturn == '0 && n < 20) begin
            step();
            n++;
        end
        if (exp_q.size() == 0) begin
            check("sb_underflow", 32'(exp_q.size()), 32'd1);
            e = '0;
        end else begin
            e = exp_q.pop_front();
        end
        check("myturn", 32'(bus.myturn), 32'(e));
        idx = 0;
        for (int i = 0; i < NT; i++) if (e[i]) idx = i;
        check("cursor_at_grant", 32'(bus.cursor), 32'(idx));
    endtask

    task automatic respond(input int idx, input int dly, input bit back);
        repeat (dly) step();
        bus.passfwd[idx] = ~back;
        bus.passbak[idx] = back;
        step();
        bus.passfwd = '0;
        bus.passbak = '0;
    endtask

    task automatic start_solve();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        check("clear_all", 32'(bus.tile_clear), 32'hF);
        check("busy_clear", 32'(bus.busy), 32'd1);
    endtask

    initial begin
        int c;
        n_cmp = 0;
        n_err = 0;
        reset = 1'b1;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.passfwd = '0;
        bus.passbak = '0;
        step();
        step();
        reset = 1'b0;
        check("rst_myturn", 32'(bus.myturn), 32'd0);
        check("rst_clear", 32'(bus.tile_clear), 32'd0);
        check("rst_cursor", 32'(bus.cursor), 32'd0);
        check("rst_steps", 32'(bus.steps), 32'd0);
        check("rst_flags", {29'd0, bus.busy, bus.done, bus.failed}, 32'd0);

        // 1: straight pass, 3-cycle replies
        start_solve();
        exp_q.push_back(4'b0001); exp_q.push_back(4'b0010);
        exp_q.push_back(4'b0100); exp_q.push_back(4'b1000);
        for (int i = 0; i < NT; i++) begin
            wait_grant(c);
            respond(c, 3, 1'b0);
        end
        check("t1_done", 32'(bus.done), 32'd1);
        check("t1_busy", 32'(bus.busy), 32'd0);
        check("t1_steps", 32'(bus.steps), 32'd4);
        check("t1_cursor", 32'(bus.cursor), 32'd3);

        // 2: tile 2 backtracks once
        start_solve();
        exp_q.push_back(4'b0001); exp_q.push_back(4'b0010); exp_q.push_back(4'b0100);
        wait_grant(c); respond(c, 1, 1'b0);
        wait_grant(c); respond(c, 2, 1'b0);
        wait_grant(c); respond(c, 1, 1'b1);
        check("t2_retreat_clear", 32'(bus.tile_clear), 32'b0100);
        check("t2_retreat_myturn", 32'(bus.myturn), 32'd0);
        exp_q.push_back(4'b0010); exp_q.push_back(4'b0100); exp_q.push_back(4'b1000);
        for (int i = 0; i < 3; i++) begin
            wait_grant(c);
            respond(c, i + 1, 1'b0);
        end
        check("t2_done", 32'(bus.done), 32'd1);
        check("t2_steps", 32'(bus.steps), 32'd6);

        // 3: tile 0 exhausts immediately
        start_solve();
        check("t3_done_cleared", 32'(bus.done), 32'd0);
        exp_q.push_back(4'b0001);
        wait_grant(c); respond(c, 2, 1'b1);
        check("t3_failed", 32'(bus.failed), 32'd1);
        check("t3_busy", 32'(bus.busy), 32'd0);
        check("t3_no_clear0", 32'(bus.tile_clear), 32'd0);
        step();
        check("t3_failed_sticky", 32'(bus.failed), 32'd1);
        start_solve();
        check("t3_failed_cleared", 32'(bus.failed), 32'd0);

        // 4: spurious bits ignored, then collision on tile 0
        exp_q.push_back(4'b0001);
        wait_grant(c);
        step();
        bus.passfwd = 4'b1000;
        bus.passbak = 4'b0010;
        step();
        bus.passfwd = '0;
        bus.passbak = '0;
        step();
        check("t4_spur_myturn", 32'(bus.myturn), 32'd0);
        check("t4_spur_clear", 32'(bus.tile_clear), 32'd0);
        check("t4_spur_cursor", 32'(bus.cursor), 32'd0);
        check("t4_spur_busy", 32'(bus.busy), 32'd1);
        check("t4_spur_steps", 32'(bus.steps), 32'd1);
        bus.passfwd = 4'b0001;
        bus.passbak = 4'b0001;
        step();
        bus.passfwd = '0;
        bus.passbak = '0;
        check("t4_collide_failed", 32'(bus.failed), 32'd1);
        check("t4_collide_done", 32'(bus.done), 32'd0);

        // 5: abort while waiting on tile 2
        start_solve();
        exp_q.push_back(4'b0001); exp_q.push_back(4'b0010); exp_q.push_back(4'b0100);
        wait_grant(c); respond(c, 1, 1'b0);
        wait_grant(c); respond(c, 1, 1'b0);
        wait_grant(c);
        step();
        check("t5_cursor_pre", 32'(bus.cursor), 32'd2);
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        check("t5_busy", 32'(bus.busy), 32'd0);
        check("t5_cursor", 32'(bus.cursor), 32'd0);
        check("t5_steps", 32'(bus.steps), 32'd0);
        check("t5_outs", {26'd0, bus.myturn, bus.done, bus.failed}, 32'd0);
        repeat (3) step();
        check("t5_quiet", {28'd0, bus.myturn}, 32'd0);

        // 6: ping-pong between tiles 0 and 1 for 20 grants, with a mid-solve start
        start_solve();
        for (int i = 0; i < 10; i++) begin
            exp_q.push_back(4'b0001);
            exp_q.push_back(4'b0010);
            wait_grant(c); respond(c, 1, 1'b0);
            wait_grant(c);
            if (i == 5) begin
                bus.start = 1'b1;
                step();
                bus.start = 1'b0;
                check("t6_start_ignored_clear", 32'(bus.tile_clear), 32'd0);
                check("t6_start_ignored_busy", 32'(bus.busy), 32'd1);
            end
            respond(c, 1, 1'b1);
            check("t6_retreat_clear", 32'(bus.tile_clear), 32'b0010);
        end
        check("t6_steps_sat", 32'(bus.steps), 32'd15);
        exp_q.push_back(4'b0001);
        wait_grant(c); respond(c, 1, 1'b1);
        check("t6_failed", 32'(bus.failed), 32'd1);
        check("t6_steps_hold", 32'(bus.steps), 32'd15);

        check("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
